// File: rtl/div_seq.sv
// div_seq: iterative restoring divider, one trial subtraction per cycle,
// signed/unsigned, fixed WIDTH+2 cycle latency with a busy/done handshake.  Rev 1.0
`default_nettype none

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // The shifted remainder keeps its top bit so divisors above 2^(WIDTH-1)
  // still compare correctly; when the trial fits the true difference is < 2^WIDTH.
  always_comb begin
    a_mag  = (sign && a[WIDTH-1]) ? -a : a;
    b_mag  = (sign && b[WIDTH-1]) ? -b : b;
    rem_sh = {rem, quo[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, dvsr});
    diff   = rem_sh[WIDTH-1:0] - dvsr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sign & a[WIDTH-1];
            dvsr  <= b_mag;
            quo   <= a_mag;
            rem   <= '0;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          quo <= {quo[WIDTH-2:0], fits};
          rem <= fits ? diff : rem_sh[WIDTH-1:0];
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          q        <= neg_q ? -quo : quo;
          r        <= neg_r ? -rem : rem;
          div_zero <= (dvsr == '0);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// tb_div_seq: directed-vector bench for div_seq (WIDTH=32).
`default_nettype none

module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .a        (a),
    .b        (b),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; start is seen by the next rising edge (E0).
  task automatic launch(input logic s, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    sign  = s;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts at the negedge after E0; returns on the negedge where done is high.
  task automatic wait_done(output int edges, output int bc);
    edges = 0;
    bc    = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eq,
                        input logic [31:0] er, input logic edz);
    int edges;
    int bc;
    launch(s, av, bv);
    wait_done(edges, bc);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("FAIL %s latency: got %0d negedges after E0, expected 33", name, edges);
    end
    checks++;
    if (bc !== 33) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected 33", name, bc);
    end
    checks++;
    if (q !== eq) begin
      errors++;
      $display("FAIL %s q: got %h, expected %h", name, q, eq);
    end
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL %s r: got %h, expected %h", name, r, er);
    end
    checks++;
    if (div_zero !== edz) begin
      errors++;
      $display("FAIL %s div_zero: got %b, expected %b", name, div_zero, edz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b one cycle later, expected 0", name, done);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (q !== 32'h0 || r !== 32'h0) begin
      errors++;
      $display("FAIL reset q/r: got %h/%h, expected 0/0", q, r);
    end
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags: got busy,done,dz=%b, expected 000", {busy, done, div_zero});
    end
  endtask

  task automatic test_unsigned;
    run_op("u_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op("u_5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    run_op("u_big_div", 1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 1'b0);
  endtask

  task automatic test_signed;
    run_op("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    run_op("s_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);
    run_op("s_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
  endtask

  task automatic test_div_zero;
    run_op("u_div0", 1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    run_op("after_div0", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("s_div0_neg", 1'b1, 32'hFFFFFFFB, 32'h0, 32'd1, 32'hFFFFFFFB, 1'b1);
  endtask

  task automatic test_back_to_back;
    int edges;
    int bc;
    launch(1'b0, 32'd1000, 32'd10);
    edges = 0;
    bc    = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (edges == 5 || edges == 20) begin
        start = 1'b1;
        a     = 32'd999;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("FAIL hs_ignore latency: got %0d, expected 33", edges);
    end
    checks++;
    if (q !== 32'd100 || r !== 32'd0) begin
      errors++;
      $display("FAIL hs_ignore q/r: got %0d/%0d, expected 100/0", q, r);
    end
    // Issue the next request during the done cycle.
    launch(1'b0, 32'd77, 32'd5);
    wait_done(edges, bc);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("FAIL b2b latency: got %0d, expected 33", edges);
    end
    checks++;
    if (q !== 32'd15 || r !== 32'd2) begin
      errors++;
      $display("FAIL b2b q/r: got %0d/%0d, expected 15/2", q, r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    launch(1'b0, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 32'h0 || r !== 32'h0) begin
      errors++;
      $display("FAIL midrst q/r: got %h/%h, expected 0/0", q, r);
    end
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL midrst flags: got %b, expected 000", {busy, done, div_zero});
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst no_done: got activity after abort, expected none");
    end
    run_op("after_rst", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
